bin2bcd_seq_iceqman: RTL and testbench
======================================

// Module: bin2bcd_seq_iceqman
// PURPOSE
//  Sequential double-dabble converter between the ALU result register and the
//  7-segment decoders. Converts the 16-bit displayed result to 5 BCD digits so
//  results show in decimal, plus a leading-zero blank mask for the digit drivers.
//  One shift/adjust step per clock; start/busy/done handshake with the controller.
// PARAMETERS
//  WIDTH   16  binary input width; also the number of conversion steps
//  DIGITS  5   BCD digits out; 10^DIGITS must exceed 2^WIDTH-1
// PORTS
//  clock    in   1          system clock, all state on rising edge
//  reset    in   1          asynchronous, active-high; returns block to IDLE
//  start    in   1          request conversion of bin_in; sampled in IDLE only
//  bin_in   in   WIDTH      unsigned binary value, captured on accepted start
//  busy     out  1          high in any state other than IDLE
//  done     out  1          one-cycle pulse: bcd_out/blank just updated
//  bcd_out  out  4*DIGITS   digit i at [4i+3:4i], digit 0 = least significant
//  blank    out  DIGITS     bit i=1: digit i is a leading zero (blank it)
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, shift/count regs=0, busy=0, done=0,
//   bcd_out=0, blank={DIGITS-1{1},1'b0} (shows a single "0").
//  FSM: IDLE -> CONVERT -> DONE -> IDLE.
//   IDLE: start=1 on edge k -> bin_reg<=bin_in, bcd_acc<=0, count<=0, CONVERT.
//   CONVERT: each edge, for every digit of bcd_acc: if >=5 add 3 (4-bit, no
//    carry out); then shift {bcd_acc,bin_reg} left 1; count++. When count
//    reaches WIDTH-1 on that edge's step, go to DONE (WIDTH steps total).
//   DONE: on edge k+WIDTH+1, bcd_out<=bcd_acc, blank<=computed mask, done<=1,
//    state<=IDLE. done is registered, high exactly one cycle.
//  Latency: done high WIDTH+1 edges after the edge that accepted start (17).
//  bcd_out/blank hold last result until next done; never show partial values.
//  blank: bit i=1 iff digits i..DIGITS-1 are all zero, except bit 0 always 0.
//  start in CONVERT or DONE (busy=1): ignored, not queued; bin_in not sampled.
//  start held high continuously: new conversion accepted the edge after done.
//  bin_in changes during conversion: no effect (captured copy used).
//  reset mid-conversion: immediate abort, outputs to reset values, no done.
//  Arithmetic: bcd_acc is 4*DIGITS bits; no overflow possible for legal params.
// TESTING
//  reset, start with bin_in=0 -> done after 17 edges, bcd_out=20'h00000, blank=5'b11110
//  bin_in=16'hFFFF (65535) -> bcd_out=20'h65535, blank=5'b00000
//  bin_in=1234 -> bcd_out=20'h01234, blank=5'b10000; bin_in=10 -> 20'h00010, blank=5'b11100
//  start 1234, pulse start with bin_in=9 at step 5 -> only 01234 reported, single done
//  reset asserted at step 8 of 65535 -> busy=0, bcd_out=0, no done; next start 42 -> 20'h00042
//  start held high, bin_in=99 then 100 after first done -> 00099 then 00100, done 18 edges apart

Source files
------------

// File: rtl/bin2bcd_seq_iceqman.sv
// Sequential double-dabble binary to BCD converter with leading-zero blank mask.
// One shift/adjust step per clock, start/busy/done handshake.
module bin2bcd_seq_iceqman #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]     LAST_STEP = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]  bin_reg;
  logic [BW-1:0]     bcd_acc;
  logic [CW-1:0]     count;

  logic [BW-1:0]     adj;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] blank_nxt;
  logic              zero_run;
  logic              accept;
  logic              last;

  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) && start;
  assign last   = (count == LAST_STEP);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: idle until start, WIDTH steps, then one publish cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Add-3 correction of every digit that is 5 or more, before the shift
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd_acc[4*i +: 4];
      end
    end
  end

  // Per-digit zero flags of the finished accumulator
  always_comb begin
    digit_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_zero[i] = (bcd_acc[4*i +: 4] == 4'd0);
    end
  end

  // Leading-zero mask: digit i blank when it and all higher digits are zero;
  // the units digit always shows so zero displays as a single "0"
  always_comb begin
    zero_run  = 1'b1;
    blank_nxt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & digit_zero[i];
      blank_nxt[i] = zero_run;
    end
    blank_nxt[0] = 1'b0;
  end

  // Datapath: capture on accept, then shift {bcd_acc, bin_reg} left each step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_reg <= '0;
      bcd_acc <= '0;
      count   <= '0;
    end else if (accept) begin
      bin_reg <= bin_in;
      bcd_acc <= '0;
      count   <= '0;
    end else if (state == S_CONVERT) begin
      bcd_acc <= {adj[BW-2:0], bin_reg[WIDTH-1]};
      bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
      count   <= count + CW'(1);
    end
  end

  // Result registers: only updated in the publish cycle, with a one-cycle done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_out <= '0;
      blank   <= BLANK_RST;
      done    <= 1'b0;
    end else if (state == S_DONE) begin
      bcd_out <= bcd_acc;
      blank   <= blank_nxt;
      done    <= 1'b1;
    end else begin
      done    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_iceqman.sv
// Directed bench for bin2bcd_seq_iceqman: vector table plus
// hand-written handshake, abort and back-to-back sequences.
module tb_bin2bcd_seq_iceqman;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic [4:0]  blank;

  int n_cmp;
  int n_err;
  int cyc;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blk;
  } vec_t;

  vec_t vecs[10];

  bin2bcd_seq_iceqman #(
    .WIDTH (16),
    .DIGITS(5)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd_out(bcd_out),
    .blank  (blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for done after acceptance edge k; lat = -1 if it never comes
  task automatic wait_done(input int k, input int limit,
                           output int lat);
    lat = -1;
    while (cyc - k < limit) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = cyc - k;
        break;
      end
    end
  endtask

  // Full conversion; bin_in is scrambled after acceptance
  task automatic convert(input logic [15:0] v, output int lat,
                         output logic [19:0] bcd,
                         output logic [4:0] blk);
    int k;
    @(negedge clock);
    start  = 1'b1;
    bin_in = v;
    @(posedge clock);
    #1;
    k = cyc;
    @(negedge clock);
    start  = 1'b0;
    bin_in = ~v;
    wait_done(k, 40, lat);
    bcd = bcd_out;
    blk = blank;
  endtask

  initial begin
    int          lat;
    int          lat2;
    int          k;
    int          t1;
    int          ndone;
    logic [19:0] bcd;
    logic [4:0]  blk;

    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{16'd0,     20'h00000, 5'b11110};
    vecs[1] = '{16'd65535, 20'h65535, 5'b00000};
    vecs[2] = '{16'd1234,  20'h01234, 5'b10000};
    vecs[3] = '{16'd10,    20'h00010, 5'b11100};
    vecs[4] = '{16'd5,     20'h00005, 5'b11110};
    vecs[5] = '{16'd1000,  20'h01000, 5'b10000};
    vecs[6] = '{16'd59999, 20'h59999, 5'b00000};
    vecs[7] = '{16'd10000, 20'h10000, 5'b00000};
    vecs[8] = '{16'd100,   20'h00100, 5'b11000};
    vecs[9] = '{16'd9,     20'h00009, 5'b11110};

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_bcd",   32'(bcd_out), 32'h0);
    check("rst_blank", 32'(blank),   32'b11110);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].bin, lat, bcd, blk);
      check($sformatf("v%0d_lat", i),   32'(lat), 32'd17);
      check($sformatf("v%0d_bcd", i),   32'(bcd), 32'(vecs[i].bcd));
      check($sformatf("v%0d_blank", i), 32'(blk), 32'(vecs[i].blk));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_idle", i),  32'(busy), 32'd0);
    end

    // Start pulse during conversion must be ignored, not queued
    @(negedge clock);
    start  = 1'b1;
    bin_in = 16'd1234;
    @(posedge clock);
    #1;
    k     = cyc;
    ndone = 0;
    lat   = -1;
    bcd   = '0;
    check("ign_busy", 32'(busy), 32'd1);
    for (int s = 1; s <= 45; s++) begin
      @(negedge clock);
      if (s == 5) begin
        start  = 1'b1;
        bin_in = 16'd9;
      end else begin
        start  = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc - k;
          bcd = bcd_out;
        end
      end
    end
    check("ign_ndone", 32'(ndone),   32'd1);
    check("ign_lat",   32'(lat),     32'd17);
    check("ign_bcd",   32'(bcd),     32'h01234);
    check("ign_hold",  32'(bcd_out), 32'h01234);

    // Reset mid-conversion aborts with no done
    @(negedge clock);
    start  = 1'b1;
    bin_in = 16'd65535;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy",  32'(busy),    32'd0);
    check("abort_bcd",   32'(bcd_out), 32'h0);
    check("abort_blank", 32'(blank),   32'b11110);
    @(negedge clock);
    reset = 1'b0;
    k = cyc;
    wait_done(k, 25, lat);
    check("abort_nodone", 32'(lat), 32'hFFFF_FFFF);
    convert(16'd42, lat, bcd, blk);
    check("after_lat",   32'(lat), 32'd17);
    check("after_bcd",   32'(bcd), 32'h00042);
    check("after_blank", 32'(blk), 32'b11100);

    // Start held high: back-to-back conversions 18 edges apart
    @(negedge clock);
    start  = 1'b1;
    bin_in = 16'd99;
    @(posedge clock);
    #1;
    k = cyc;
    wait_done(k, 40, lat);
    t1 = cyc;
    check("held1_lat", 32'(lat),     32'd17);
    check("held1_bcd", 32'(bcd_out), 32'h00099);
    @(negedge clock);
    bin_in = 16'd100;
    wait_done(t1, 40, lat2);
    check("held_gap",    32'(lat2),    32'd18);
    check("held2_bcd",   32'(bcd_out), 32'h00100);
    check("held2_blank", 32'(blank),   32'b11000);
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("held_quiet", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
